iob_cache_be_ctrl: RTL and testbench



---
 rtl/iob_cache_be_ctrl_pkg.sv | 12 +
 rtl/iob_cache_be_ctrl.sv | 148 ++++++++++++++
 tb/tb_iob_cache_be_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/iob_cache_be_ctrl_pkg.sv
// Shared types for the cache backend controller: FSM state encoding.
package iob_cache_be_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WTB_POP = 3'd1,
    ST_WTB_REQ = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_WAIT = 3'd4
  } be_state_e;

endpackage

// File: rtl/iob_cache_be_ctrl.sv
// Cache backend controller: drains the write buffer and performs line fills,
// one backend transaction at a time, with writes taking priority over fills.
module iob_cache_be_ctrl
  import iob_cache_be_ctrl_pkg::*;
#(
  parameter int BE_ADDR_W  = 32,
  parameter int BE_DATA_W  = 32,
  parameter int LINE_OFF_W = 2,
  parameter int WTB_DATA_W = BE_ADDR_W + BE_DATA_W + BE_DATA_W / 8
) (
  input  logic                                          clk_i,
  input  logic                                          rst_i,
  input  logic                                          wtb_empty_i,
  output logic                                          wtb_ren_o,
  input  logic [WTB_DATA_W-1:0]                         wtb_rdata_i,
  input  logic                                          rd_avalid_i,
  input  logic [BE_ADDR_W-1:0]                          rd_addr_i,
  output logic                                          rd_rvalid_o,
  output logic [((LINE_OFF_W > 0) ? LINE_OFF_W : 1)-1:0] rd_word_o,
  output logic [BE_DATA_W-1:0]                          rd_rdata_o,
  output logic                                          rd_ready_o,
  output logic                                          be_avalid_o,
  output logic [BE_ADDR_W-1:0]                          be_addr_o,
  output logic [BE_DATA_W-1:0]                          be_wdata_o,
  output logic [BE_DATA_W/8-1:0]                        be_wstrb_o,
  input  logic                                          be_ready_i,
  input  logic                                          be_rvalid_i,
  input  logic [BE_DATA_W-1:0]                          be_rdata_i,
  output logic                                          idle_o
);

  localparam int BE_NBYTES  = BE_DATA_W / 8;
  localparam int NB_W       = $clog2(BE_NBYTES);
  localparam int CNT_W      = (LINE_OFF_W > 0) ? LINE_OFF_W : 1;
  localparam int LINE_WORDS = 2 ** LINE_OFF_W;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(LINE_WORDS - 1);
  localparam logic [BE_ADDR_W-1:0] LINE_MASK =
    ~((BE_ADDR_W'(1) << (LINE_OFF_W + NB_W)) - BE_ADDR_W'(1));

  be_state_e              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [BE_ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [BE_DATA_W-1:0]   wr_data_q, wr_data_d;
  logic [BE_NBYTES-1:0]   wr_strb_q, wr_strb_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_strb_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_strb_q <= wr_strb_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    wr_strb_d   = wr_strb_q;
    wtb_ren_o   = 1'b0;
    rd_rvalid_o = 1'b0;
    rd_rdata_o  = '0;
    rd_ready_o  = 1'b0;
    be_avalid_o = 1'b0;
    be_addr_o   = '0;
    be_wdata_o  = '0;
    be_wstrb_o  = '0;
    case (state_q)
      ST_IDLE: begin
        if (!wtb_empty_i) begin
          wtb_ren_o = 1'b1;
          state_d   = ST_WTB_POP;
        end else if (rd_avalid_i) begin
          cnt_d   = '0;
          state_d = ST_RD_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WTB_POP: begin
        wr_addr_d = wtb_rdata_i[WTB_DATA_W-1 -: BE_ADDR_W];
        wr_data_d = wtb_rdata_i[BE_DATA_W+BE_NBYTES-1 -: BE_DATA_W];
        wr_strb_d = wtb_rdata_i[BE_NBYTES-1:0];
        state_d   = ST_WTB_REQ;
      end
      ST_WTB_REQ: begin
        be_avalid_o = 1'b1;
        be_addr_o   = wr_addr_q;
        be_wdata_o  = wr_data_q;
        be_wstrb_o  = wr_strb_q;
        if (be_ready_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WTB_REQ;
        end
      end
      ST_RD_REQ: begin
        // Counter is below LINE_WORDS, so OR-ing it in never carries past the line offset.
        be_avalid_o = 1'b1;
        be_addr_o   = (rd_addr_i & LINE_MASK) | (BE_ADDR_W'(cnt_q) << NB_W);
        if (be_ready_i) begin
          state_d = ST_RD_WAIT;
        end else begin
          state_d = ST_RD_REQ;
        end
      end
      ST_RD_WAIT: begin
        if (be_rvalid_i) begin
          rd_rvalid_o = 1'b1;
          rd_rdata_o  = be_rdata_i;
          if (cnt_q == LAST_WORD) begin
            rd_ready_o = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = ST_RD_REQ;
          end
        end else begin
          state_d = ST_RD_WAIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // A reset cycle must not pop the buffer or signal fill data that is being abandoned.
    if (rst_i) begin
      wtb_ren_o   = 1'b0;
      rd_rvalid_o = 1'b0;
      rd_rdata_o  = '0;
      rd_ready_o  = 1'b0;
    end else begin
      wtb_ren_o = wtb_ren_o;
    end
  end

  assign rd_word_o = (LINE_OFF_W > 0) ? cnt_q : '0;
  assign idle_o    = (state_q == ST_IDLE) && wtb_empty_i;

endmodule

// File: tb/tb_iob_cache_be_ctrl.sv
// Self-checking bench for iob_cache_be_ctrl: write-buffer, requester and
// backend memory models with a program-order reference memory.
module tb_iob_cache_be_ctrl;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int OW = 2;
  localparam int NB = 4;
  localparam int LW = 4;
  localparam int WW = AW + DW + NB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_i = 1'b1;
  logic          wtb_empty_i = 1'b1;
  logic          wtb_ren_o;
  logic [WW-1:0] wtb_rdata_i = '0;
  logic          rd_avalid_i = 1'b0;
  logic [AW-1:0] rd_addr_i = '0;
  logic          rd_rvalid_o;
  logic [OW-1:0] rd_word_o;
  logic [DW-1:0] rd_rdata_o;
  logic          rd_ready_o;
  logic          be_avalid_o;
  logic [AW-1:0] be_addr_o;
  logic [DW-1:0] be_wdata_o;
  logic [NB-1:0] be_wstrb_o;
  logic          be_ready_i = 1'b0;
  logic          be_rvalid_i = 1'b0;
  logic [DW-1:0] be_rdata_i = '0;
  logic          idle_o;

  iob_cache_be_ctrl #(.BE_ADDR_W(AW), .BE_DATA_W(DW), .LINE_OFF_W(OW)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .wtb_empty_i(wtb_empty_i), .wtb_ren_o(wtb_ren_o), .wtb_rdata_i(wtb_rdata_i),
    .rd_avalid_i(rd_avalid_i), .rd_addr_i(rd_addr_i), .rd_rvalid_o(rd_rvalid_o),
    .rd_word_o(rd_word_o), .rd_rdata_o(rd_rdata_o), .rd_ready_o(rd_ready_o),
    .be_avalid_o(be_avalid_o), .be_addr_o(be_addr_o), .be_wdata_o(be_wdata_o),
    .be_wstrb_o(be_wstrb_o), .be_ready_i(be_ready_i), .be_rvalid_i(be_rvalid_i),
    .be_rdata_i(be_rdata_i), .idle_o(idle_o)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_t;

  int n_checks = 0;
  int n_errors = 0;

  wr_t wtb_q[$];
  wr_t inflight_q[$];
  wr_t push_q[$];
  logic [31:0] ref_mem[int];
  logic [31:0] be_mem[int];

  bit want_rst = 1'b1;
  int ready_mode = 1;
  int rv_delay_max = 0;
  bit spurious_en = 1'b0;
  bit req_start = 1'b0;
  logic [31:0] req_addr = '0;
  bit req_active = 1'b0;
  logic [31:0] exp_line[LW];
  int rd_idx = 0;
  int wr_pushed = 0, wr_needed = 0, wr_done = 0;
  bit fill_reading = 1'b0;
  bit rv_pending = 1'b0;
  int rv_wait = 0;
  logic [31:0] rv_addr = '0;
  int rv_word = 0;
  bit drove_rv_real = 1'b0;
  bit pop_pending = 1'b0;
  wr_t pop_entry;
  int cyc = 0, fill_start_cyc = 0, last_fill_len = 0, fills_done = 0, stall_cnt = 0;
  logic [31:0] last_word0 = '0;
  bit prev_stall = 1'b0;
  logic [31:0] prev_addr, prev_wdata;
  logic [3:0] prev_wstrb;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input int a);
    return 32'(a) * 32'h9E37_79B9 + 32'h0000_1234;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_get(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] be_get(input int a);
    return be_mem.exists(a) ? be_mem[a] : init_word(a);
  endfunction

  task push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    wr_t e;
    e.addr = a; e.data = d; e.strb = s;
    push_q.push_back(e);
  endtask

  // Drive all inputs shortly after the rising edge.
  task drive();
    wr_t e;
    logic [31:0] base;
    cyc++;
    rst_i = want_rst;
    while (push_q.size() != 0) begin
      e = push_q.pop_front();
      wtb_q.push_back(e);
      ref_mem[int'(e.addr >> 2)] = merge(ref_get(int'(e.addr >> 2)), e.data, e.strb);
      wr_pushed++;
    end
    wtb_empty_i = (wtb_q.size() == 0);
    wtb_rdata_i = pop_pending ? WW'(pop_entry) : {$urandom(), $urandom(), 4'($urandom())};
    pop_pending = 1'b0;
    if (req_start && !req_active) begin
      req_start = 1'b0;
      req_active = 1'b1;
      rd_avalid_i = 1'b1;
      rd_addr_i = req_addr;
      base = req_addr & ~32'hF;
      for (int i = 0; i < LW; i++) exp_line[i] = ref_get(int'(base >> 2) + i);
      wr_needed = wr_pushed;
      rd_idx = 0;
      fill_start_cyc = cyc;
    end else if (!req_active) begin
      rd_avalid_i = 1'b0;
      rd_addr_i = $urandom();
    end
    be_ready_i = (ready_mode == 0) ? ($urandom_range(0, 2) != 0) : (ready_mode == 1);
    drove_rv_real = 1'b0;
    be_rdata_i = $urandom();
    be_rvalid_i = 1'b0;
    if (rv_pending) begin
      if (rv_wait == 0) begin
        be_rvalid_i = 1'b1;
        be_rdata_i = be_get(int'(rv_addr >> 2));
        drove_rv_real = 1'b1;
        rv_pending = 1'b0;
      end else begin
        rv_wait--;
      end
    end else begin
      be_rvalid_i = spurious_en && ($urandom_range(0, 5) == 0);
    end
  endtask

  // Observe outputs at the falling edge and update the models.
  task sample();
    wr_t e;
    if (rst_i) begin
      check("rst_no_ready", rd_ready_o, 1'b0);
      check("rst_no_ren", wtb_ren_o, 1'b0);
      check("rst_no_rvalid", rd_rvalid_o, 1'b0);
      rv_pending = 1'b0; req_active = 1'b0; fill_reading = 1'b0;
      inflight_q.delete(); pop_pending = 1'b0; prev_stall = 1'b0;
      return;
    end
    if (prev_stall) begin
      check("stall_avalid", be_avalid_o, 1'b1);
      check("stall_addr", be_addr_o, prev_addr);
      check("stall_wdata", be_wdata_o, prev_wdata);
      check("stall_wstrb", be_wstrb_o, prev_wstrb);
    end
    if (!wtb_empty_i) check("idle_wtb_pending", idle_o, 1'b0);
    else if (be_avalid_o) check("idle_be_busy", idle_o, 1'b0);
    if (rv_pending) check("one_outstanding", be_avalid_o, 1'b0);
    if (wtb_ren_o) begin
      check("pop_nonempty", wtb_q.size() != 0, 1'b1);
      if (wtb_q.size() != 0) begin
        pop_entry = wtb_q.pop_front();
        inflight_q.push_back(pop_entry);
        pop_pending = 1'b1;
      end
    end
    if (be_avalid_o && be_ready_i) begin
      if (be_wstrb_o != 4'h0) begin
        check("wr_during_fill", fill_reading, 1'b0);
        if (inflight_q.size() == 0) check("wr_unexpected", 1'b1, 1'b0);
        else begin
          e = inflight_q.pop_front();
          check("wr_addr", be_addr_o, e.addr);
          check("wr_data", be_wdata_o, e.data);
          check("wr_strb", be_wstrb_o, e.strb);
          be_mem[int'(be_addr_o >> 2)] = merge(be_get(int'(be_addr_o >> 2)), be_wdata_o, be_wstrb_o);
          wr_done++;
        end
      end else begin
        check("rd_req_active", req_active, 1'b1);
        check("rd_after_writes", wr_done >= wr_needed, 1'b1);
        check("rd_addr", be_addr_o, (req_addr & ~32'hF) + 32'(4 * rd_idx));
        fill_reading = 1'b1;
        rv_pending = 1'b1;
        rv_wait = $urandom_range(0, rv_delay_max);
        rv_addr = be_addr_o;
        rv_word = rd_idx;
        rd_idx++;
      end
    end
    if (drove_rv_real) begin
      check("rd_rvalid", rd_rvalid_o, 1'b1);
      check("rd_word", rd_word_o, 64'(rv_word));
      check("rd_rdata", rd_rdata_o, exp_line[rv_word]);
      check("rd_ready", rd_ready_o, rv_word == LW - 1);
      if (rv_word == 0) last_word0 = rd_rdata_o;
      if (rv_word == LW - 1) begin
        req_active = 1'b0;
        fill_reading = 1'b0;
        last_fill_len = cyc - fill_start_cyc;
        check("fill_min_latency", last_fill_len >= 2 * LW, 1'b1);
        fills_done++;
      end
    end else begin
      check("no_rvalid", rd_rvalid_o, 1'b0);
      check("no_ready", rd_ready_o, 1'b0);
    end
    prev_stall = be_avalid_o && !be_ready_i;
    if (prev_stall) stall_cnt++;
    prev_addr = be_addr_o; prev_wdata = be_wdata_o; prev_wstrb = be_wstrb_o;
  endtask

  task cycle();
    @(posedge clk);
    #1 drive();
    @(negedge clk);
    sample();
  endtask

  task wait_quiet(input int max_cyc, input string tag);
    bit quiet = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      cycle();
      if (!req_active && !req_start && wtb_q.size() == 0 && push_q.size() == 0 &&
          inflight_q.size() == 0 && !pop_pending && idle_o) begin
        quiet = 1'b1;
        break;
      end
    end
    check(tag, quiet, 1'b1);
  endtask

  task check_all_zero(input string tag);
    check({tag, "_avalid"}, be_avalid_o, 1'b0);
    check({tag, "_addr"}, be_addr_o, 32'h0);
    check({tag, "_wdata"}, be_wdata_o, 32'h0);
    check({tag, "_wstrb"}, be_wstrb_o, 4'h0);
    check({tag, "_ren"}, wtb_ren_o, 1'b0);
    check({tag, "_rvalid"}, rd_rvalid_o, 1'b0);
    check({tag, "_ready"}, rd_ready_o, 1'b0);
    check({tag, "_word"}, rd_word_o, 2'd0);
    check({tag, "_rdata"}, rd_rdata_o, 32'h0);
    check({tag, "_idle"}, idle_o, 1'b1);
  endtask

  initial begin
    int base_done;
    logic [31:0] d;
    bit hit;

    // Reset state
    want_rst = 1'b1;
    cycle(); cycle();
    want_rst = 1'b0;
    cycle();
    check_all_zero("reset");

    // Drain three buffered writes in order
    base_done = wr_done;
    push(32'h100, $urandom(), 4'hF);
    push(32'h104, $urandom(), 4'hF);
    push(32'h108, $urandom(), 4'hF);
    wait_quiet(14, "drain_done");
    check("drain_count", wr_done - base_done, 3);
    check("drain_mem_108", be_get(32'h108 >> 2), ref_get(32'h108 >> 2));
    check("drain_idle", idle_o, 1'b1);

    // Zero-wait line fill from a mid-line address
    req_addr = 32'h20C; req_start = 1'b1;
    wait_quiet(30, "fill_done");
    check("fill_latency", last_fill_len, 2 * LW);

    // Write pending when fill requested goes out first
    d = $urandom();
    push(32'h200, d, 4'hF);
    req_addr = 32'h200; req_start = 1'b1;
    wait_quiet(40, "order_done");
    check("order_word0", last_word0, d);

    // Backpressure during a write
    base_done = wr_done;
    stall_cnt = 0;
    ready_mode = 2;
    push(32'h180, $urandom(), 4'h5);
    for (int i = 0; i < 8; i++) cycle();
    check("bp_stalls", stall_cnt >= 5, 1'b1);
    check("bp_no_write", wr_done - base_done, 0);
    check("bp_avalid", be_avalid_o, 1'b1);
    ready_mode = 1;
    wait_quiet(10, "bp_done");
    check("bp_single_write", wr_done - base_done, 1);

    // Reset while fill word 2 is being returned
    req_addr = 32'h304; req_start = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 30; i++) begin
      cycle();
      if (rd_idx == 3 && rv_pending) begin
        hit = 1'b1;
        break;
      end
    end
    check("rst_fill_reached_w2", hit, 1'b1);
    want_rst = 1'b1;
    cycle();
    want_rst = 1'b0;
    cycle();
    check_all_zero("rst_fill");
    req_addr = 32'h304; req_start = 1'b1;
    wait_quiet(30, "refill_done");
    check("refill_latency", last_fill_len, 2 * LW);

    // Randomized traffic with backpressure, read delays and stray rvalids
    ready_mode = 0; rv_delay_max = 2; spurious_en = 1'b1;
    base_done = fills_done;
    for (int i = 0; i < 1500; i++) begin
      cycle();
      if (((!req_active && !req_start) || fill_reading) && $urandom_range(0, 3) == 0)
        push(32'h200 + 32'(4 * $urandom_range(0, 15)), $urandom(), 4'($urandom_range(1, 15)));
      if (!req_active && !req_start && $urandom_range(0, 9) == 0) begin
        req_addr = 32'h200 + 32'($urandom_range(0, 63));
        req_start = 1'b1;
      end
    end
    spurious_en = 1'b0;
    wait_quiet(400, "random_quiet");
    check("random_fills_seen", fills_done > base_done, 1'b1);
    check("random_idle", idle_o, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
